rr_shared_reg_arbiter: RTL and testbench
========================================

Name: rr_shared_reg_arbiter

Overview:
- Round-robin arbiter that shares a single enable-gated data register among NREQ requesters.
- Each requester presents req plus write data. The arbiter picks one winner per cycle, captures its data into the shared register, and returns a registered one-hot grant.
- Optional per-requester lock gives the winner consecutive write cycles, bounded by LOCK_MAX.
- Sits in front of shared configuration/status registers written by multiple agents.

Parameters:
- NREQ, 4: number of requesters, >=1.
- DWIDTH, 8: shared register width.
- LOCK_MAX, 4: max writes in one lock session, >=1.
- SW: derived, max(1, clog2(NREQ)); width of source index.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NREQ  per-requester write request.
- lock  input  NREQ  per-requester lock request; only meaningful with req.
- wdata  input  NREQ*DWIDTH  packed write data; requester i at bits [i*DWIDTH +: DWIDTH].
- gnt  output  NREQ  registered one-hot grant; gnt[i]=1 in the cycle after wdata[i] was captured.
- q  output  DWIDTH  shared register contents.
- q_valid  output  1  equals |gnt; q updated at the preceding edge.
- q_src  output  SW  index of last requester written (holds when no write).
- locked  output  1  FSM in LOCKED state.

Behaviour:
- Reset (async assert, sync release): gnt=0, q=0, q_valid=0, q_src=0, locked=0, ptr=0, state=ARB, owner=0, lock_cnt=0.
- Arbitration (state ARB):
  - Winner is the first i with req[i]=1, searching ptr, ptr+1, ..., wrapping modulo NREQ.
  - No req: no write; gnt=0 next cycle; q, q_src, ptr hold.
  - Winner i: at the edge, q<=wdata[i], q_src<=i, gnt<=onehot(i).
  - If lock[i]=0: ptr<=(i+1) mod NREQ, stay ARB.
  - If lock[i]=1 and LOCK_MAX>1: state<=LOCKED, owner<=i, lock_cnt<=1, ptr unchanged.
  - If lock[i]=1 and LOCK_MAX=1: treat as unlocked.
- Latency: request sampled at edge k; data in q and gnt asserted during cycle k..k+1 (one edge). A requester holding req after its grant re-competes with the rotated pointer.
- LOCKED state, evaluated at each edge; only owner considered, others get no grant:
  - req[owner]=0: no write, gnt<=0, state<=ARB, ptr<=(owner+1) mod NREQ.
  - req[owner]=1, lock[owner]=0: write owner data, gnt<=onehot(owner), state<=ARB, ptr<=(owner+1) mod NREQ.
  - req[owner]=1, lock[owner]=1: write, lock_cnt++. If the new lock_cnt==LOCK_MAX, state<=ARB and ptr<=(owner+1) mod NREQ (forced release). Otherwise stay LOCKED.
- locked=1 exactly while state==LOCKED (registered).
- Lock counter width: clog2(LOCK_MAX+1). It never exceeds LOCK_MAX and is cleared on entry to ARB.
- Simultaneous requests: exactly one winner per cycle. gnt is never multi-hot.
- Requester lock input is ignored for non-winners.
- NREQ=1: ptr stays 0; q_src is a 1-bit constant 0.
- Reset mid-lock: immediate return to ARB with all outputs 0; the in-flight write is discarded (q=0).
- X-free: data of non-winning requesters never affects q.

Test Plan:
- After reset, req=0 for 5 cycles -> gnt=0, q=0, q_valid=0, locked=0 throughout.
- NREQ=4, req=4'b1111, lock=0, wdata[i]=8'h10+i held 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,...; q sequence 10,11,12,13,10; q_src 0,1,2,3,0.
- req=4'b0101 from ptr=0 -> grants alternate 0001,0100; req[1] and req[3] never granted; no idle cycles between grants.
- LOCK_MAX=4, req=1111, lock[2]=1, ptr=2 -> four consecutive gnt=0100 with locked=1 during the lock session, then forced release; next grant is 1000.
- Locked owner 1 drops req after 2 writes while req[0]=1 -> one cycle gnt=0; locked falls; then req[0] granted only after ptr rotates to 2 and wraps, i.e. gnt=0001 on the next edge (no other requesters).
- Assert rst for one cycle mid-lock, asynchronously between edges -> gnt, q, q_valid, locked go 0 immediately. After release, req=0001 -> gnt=0001 at the first edge, confirming ptr=0.

Source files
------------

// File: rtl/rr_shared_reg_arbiter_if.sv
// ---------------------------------------------------------------------------
// rr_shared_reg_arbiter_if
//
// Bundles the requester-side and register-side signals of the round-robin
// shared-register arbiter.
//
// Parameters:
//   NREQ   - number of requesters (>= 1)
//   DWIDTH - shared register width
//   SW     - source index width, max(1, clog2(NREQ))
//
// Signals:
//   req     [NREQ]          per-requester write request
//   lock    [NREQ]          per-requester lock request (qualified by req)
//   wdata   [NREQ*DWIDTH]   packed write data, requester i at [i*DWIDTH +: DWIDTH]
//   gnt     [NREQ]          registered one-hot grant
//   q       [DWIDTH]        shared register contents
//   q_valid                 |gnt, q was updated at the preceding edge
//   q_src   [SW]            index of the last requester written
//   locked                  arbiter is in a lock session
//
// Modports:
//   master - requester side (drives req/lock/wdata, observes results)
//   slave  - arbiter side
// ---------------------------------------------------------------------------
interface rr_shared_reg_arbiter_if #(
    parameter int NREQ   = 4,
    parameter int DWIDTH = 8
);
    localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]        req;
    logic [NREQ-1:0]        lock;
    logic [NREQ*DWIDTH-1:0] wdata;
    logic [NREQ-1:0]        gnt;
    logic [DWIDTH-1:0]      q;
    logic                   q_valid;
    logic [SW-1:0]          q_src;
    logic                   locked;

    modport master (
        output req,
        output lock,
        output wdata,
        input  gnt,
        input  q,
        input  q_valid,
        input  q_src,
        input  locked
    );

    modport slave (
        input  req,
        input  lock,
        input  wdata,
        output gnt,
        output q,
        output q_valid,
        output q_src,
        output locked
    );
endinterface

// File: rtl/rr_shared_reg_arbiter.sv
// ---------------------------------------------------------------------------
// rr_shared_reg_arbiter
//
// Round-robin arbiter in front of a single shared, enable-gated data
// register. Each cycle at most one requester wins; its data is captured into
// q and a registered one-hot grant is returned in the following cycle. A
// winner that also asserts lock keeps exclusive write access for up to
// LOCK_MAX consecutive writes before being forced to release.
//
// Parameters:
//   NREQ     - number of requesters (>= 1)
//   DWIDTH   - shared register width
//   LOCK_MAX - maximum writes in one lock session (>= 1)
//
// Ports:
//   clk  - clock, all state updates on the rising edge
//   rst  - asynchronous assert, active-high reset
//   bus  - slave modport of rr_shared_reg_arbiter_if
//          (req/lock/wdata in; gnt/q/q_valid/q_src/locked out)
// ---------------------------------------------------------------------------
module rr_shared_reg_arbiter #(
    parameter int NREQ     = 4,
    parameter int DWIDTH   = 8,
    parameter int LOCK_MAX = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    rr_shared_reg_arbiter_if.slave  bus
);

    localparam int SW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(LOCK_MAX + 1);
    // A one-write lock session is indistinguishable from an unlocked grant,
    // so locking is only enabled when it can actually extend ownership.
    localparam bit LOCK_EN = (LOCK_MAX > 1);

    typedef enum logic {
        ST_ARB    = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t              state_q,    state_d;
    logic [SW-1:0]       ptr_q,      ptr_d;
    logic [SW-1:0]       owner_q,    owner_d;
    logic [CW-1:0]       lock_cnt_q, lock_cnt_d;
    logic [NREQ-1:0]     gnt_q,      gnt_d;
    logic [DWIDTH-1:0]   q_q,        q_d;
    logic [SW-1:0]       q_src_q,    q_src_d;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic [SW-1:0] next_idx(input logic [SW-1:0] i);
        if (int'(i) >= NREQ - 1) begin
            return '0;
        end
        return i + 1'b1;
    endfunction

    // Per-requester data slices, so the data mux selects by index only and
    // non-winning data never reaches q.
    logic [DWIDTH-1:0] wdata_arr [NREQ];

    // Requests rotated so that position 0 corresponds to ptr; rot_idx maps
    // each rotated position back to its physical requester index.
    logic [SW-1:0]     rot_idx   [NREQ];
    logic [NREQ-1:0]   rot_req;

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            logic [SW:0] sum;

            assign wdata_arr[gi] = bus.wdata[gi*DWIDTH +: DWIDTH];

            assign sum         = {1'b0, ptr_q} + (SW+1)'(gi);
            assign rot_idx[gi] = (sum >= (SW+1)'(NREQ)) ? SW'(sum - (SW+1)'(NREQ))
                                                        : SW'(sum);
            assign rot_req[gi] = bus.req[rot_idx[gi]];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Round-robin winner: first set request at or after ptr
    // ------------------------------------------------------------------
    logic          win_found;
    logic [SW-1:0] win_idx;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        // Scan from the far end so the lowest rotated position wins.
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                win_found = 1'b1;
                win_idx   = rot_idx[k];
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state / output logic
    // ------------------------------------------------------------------
    logic [CW-1:0] cnt_inc;

    assign cnt_inc = lock_cnt_q + 1'b1;

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        gnt_d      = '0;
        q_d        = q_q;
        q_src_d    = q_src_q;

        unique case (state_q)
            ST_ARB: begin
                lock_cnt_d = '0;
                if (win_found) begin
                    q_d     = wdata_arr[win_idx];
                    q_src_d = win_idx;
                    gnt_d   = NREQ'(1) << win_idx;
                    if (LOCK_EN && bus.lock[win_idx]) begin
                        // Pointer stays put during the session; it rotates
                        // past the owner when the session ends.
                        state_d    = ST_LOCKED;
                        owner_d    = win_idx;
                        lock_cnt_d = CW'(1);
                    end else begin
                        ptr_d = next_idx(win_idx);
                    end
                end
            end

            ST_LOCKED: begin
                if (!bus.req[owner_q]) begin
                    // Owner walked away: release without a write.
                    state_d    = ST_ARB;
                    ptr_d      = next_idx(owner_q);
                    lock_cnt_d = '0;
                end else begin
                    q_d     = wdata_arr[owner_q];
                    q_src_d = owner_q;
                    gnt_d   = NREQ'(1) << owner_q;
                    if (!bus.lock[owner_q] || (cnt_inc == CW'(LOCK_MAX))) begin
                        // Final write of the session, voluntary or forced.
                        state_d    = ST_ARB;
                        ptr_d      = next_idx(owner_q);
                        lock_cnt_d = '0;
                    end else begin
                        lock_cnt_d = cnt_inc;
                    end
                end
            end

            default: begin
                state_d    = ST_ARB;
                lock_cnt_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_ARB;
            ptr_q      <= '0;
            owner_q    <= '0;
            lock_cnt_q <= '0;
            gnt_q      <= '0;
            q_q        <= '0;
            q_src_q    <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            lock_cnt_q <= lock_cnt_d;
            gnt_q      <= gnt_d;
            q_q        <= q_d;
            q_src_q    <= q_src_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.gnt     = gnt_q;
    assign bus.q       = q_q;
    assign bus.q_valid = |gnt_q;
    assign bus.q_src   = q_src_q;
    assign bus.locked  = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_rr_shared_reg_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rr_shared_reg_arbiter
//
// Directed bench for rr_shared_reg_arbiter (NREQ=4, DWIDTH=8, LOCK_MAX=4).
// Each step drives req/lock, pushes the hand-derived expected outputs onto a
// scoreboard queue, and after the next rising edge pops and compares them.
// ---------------------------------------------------------------------------
module tb_rr_shared_reg_arbiter;

    localparam int NREQ     = 4;
    localparam int DWIDTH   = 8;
    localparam int LOCK_MAX = 4;

    logic clk;
    logic rst;

    rr_shared_reg_arbiter_if #(.NREQ(NREQ), .DWIDTH(DWIDTH)) bus ();

    rr_shared_reg_arbiter #(
        .NREQ     (NREQ),
        .DWIDTH   (DWIDTH),
        .LOCK_MAX (LOCK_MAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] gnt;
        logic [7:0] q;
        logic [1:0] src;
        logic       locked;
    } exp_t;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Pop one expected record and compare every observable output.
    task automatic check_out(input string tag);
        exp_t e;
        vectors++;
        assert (sb.size() != 0) else begin
            miscompares++;
            $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            vectors++;
            assert (bus.gnt === e.gnt) else begin
                miscompares++;
                $error("FAIL %s gnt observed=%b expected=%b", tag, bus.gnt, e.gnt);
            end
            vectors++;
            assert (bus.q === e.q) else begin
                miscompares++;
                $error("FAIL %s q observed=%h expected=%h", tag, bus.q, e.q);
            end
            vectors++;
            assert (bus.q_valid === (|e.gnt)) else begin
                miscompares++;
                $error("FAIL %s q_valid observed=%b expected=%b", tag, bus.q_valid, |e.gnt);
            end
            vectors++;
            assert (bus.q_src === e.src) else begin
                miscompares++;
                $error("FAIL %s q_src observed=%0d expected=%0d", tag, bus.q_src, e.src);
            end
            vectors++;
            assert (bus.locked === e.locked) else begin
                miscompares++;
                $error("FAIL %s locked observed=%b expected=%b", tag, bus.locked, e.locked);
            end
            vectors++;
            assert ($onehot0(bus.gnt) === 1'b1) else begin
                miscompares++;
                $error("FAIL %s gnt_onehot observed=%b expected=onehot0", tag, bus.gnt);
            end
            $display("%s: req=%b lock=%b gnt=%b q=%h q_src=%0d locked=%b",
                     tag, bus.req, bus.lock, bus.gnt, bus.q, bus.q_src, bus.locked);
        end
    endtask

    // Compare the current outputs without advancing the clock.
    task automatic expect_now(input string tag, input logic [3:0] eg, input logic [7:0] eq,
                              input logic [1:0] es, input logic el);
        sb.push_back('{eg, eq, es, el});
        check_out(tag);
    endtask

    // Drive one cycle of stimulus and check the registered result.
    task automatic step(input string tag, input logic [3:0] r, input logic [3:0] l,
                        input logic [3:0] eg, input logic [7:0] eq,
                        input logic [1:0] es, input logic el);
        bus.req  = r;
        bus.lock = l;
        sb.push_back('{eg, eq, es, el});
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        bus.req   = '0;
        bus.lock  = '0;
        for (int i = 0; i < NREQ; i++) begin
            bus.wdata[i*DWIDTH +: DWIDTH] = 8'h10 + 8'(i);
        end

        // Reset state
        #12;
        expect_now("reset", 4'b0000, 8'h00, 2'd0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Idle: no requests
        for (int c = 0; c < 5; c++) begin
            step("idle", 4'b0000, 4'b0000, 4'b0000, 8'h00, 2'd0, 1'b0);
        end

        // All requesting, no lock: rotate 0,1,2,3,0,...
        for (int c = 0; c < 8; c++) begin
            step("rr_all", 4'b1111, 4'b0000, 4'b0001 << (c % 4),
                 8'h10 + 8'(c % 4), 2'(c % 4), 1'b0);
        end

        // Sparse requests from ptr=0: alternate 0 and 2 back to back
        for (int c = 0; c < 6; c++) begin
            step("rr_sparse", 4'b0101, 4'b0000, (c % 2 == 0) ? 4'b0001 : 4'b0100,
                 (c % 2 == 0) ? 8'h10 : 8'h12, (c % 2 == 0) ? 2'd0 : 2'd2, 1'b0);
        end
        // ptr=3: lone req[1] wins after wrapping, leaving ptr=2
        step("set_ptr2", 4'b0010, 4'b0000, 4'b0010, 8'h11, 2'd1, 1'b0);

        // Lock session by requester 2: four writes, then forced release
        step("lock2_w1", 4'b1111, 4'b0100, 4'b0100, 8'h12, 2'd2, 1'b1);
        step("lock2_w2", 4'b1111, 4'b0100, 4'b0100, 8'h12, 2'd2, 1'b1);
        step("lock2_w3", 4'b1111, 4'b0100, 4'b0100, 8'h12, 2'd2, 1'b1);
        step("lock2_w4", 4'b1111, 4'b0100, 4'b0100, 8'h12, 2'd2, 1'b0);
        step("after_lock2", 4'b1111, 4'b0100, 4'b1000, 8'h13, 2'd3, 1'b0);

        // ptr=0. Requester 1 locks, writes twice, then drops req while req[0] waits
        step("lock1_w1", 4'b0010, 4'b0010, 4'b0010, 8'h11, 2'd1, 1'b1);
        step("lock1_w2", 4'b0011, 4'b0010, 4'b0010, 8'h11, 2'd1, 1'b1);
        step("lock1_drop", 4'b0001, 4'b0000, 4'b0000, 8'h11, 2'd1, 1'b0);
        step("after_drop", 4'b0001, 4'b0000, 4'b0001, 8'h10, 2'd0, 1'b0);

        // ptr=1. Requester 2 locks; reset arrives between edges mid-session
        step("lock2b_w1", 4'b0100, 4'b0100, 4'b0100, 8'h12, 2'd2, 1'b1);
        #3;
        rst = 1'b1;
        #1;
        expect_now("async_rst", 4'b0000, 8'h00, 2'd0, 1'b0);
        @(posedge clk);
        #1;
        expect_now("rst_held", 4'b0000, 8'h00, 2'd0, 1'b0);
        #2;
        rst = 1'b0;
        bus.lock = '0;

        // ptr back at 0 after reset
        step("post_rst", 4'b0001, 4'b0000, 4'b0001, 8'h10, 2'd0, 1'b0);
        step("post_rst_rot", 4'b0011, 4'b0000, 4'b0010, 8'h11, 2'd1, 1'b0);
        step("final_idle", 4'b0000, 4'b0000, 4'b0000, 8'h11, 2'd1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
